// File: rtl/bip_debug_pkg.sv
// Shared constants for the BIP debug unit: FSM encoding, host command bytes,
// frame status codes and the result frame length.
package bip_debug_pkg;

    // FSM state encoding
    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_CLEAR   = 3'd1;
    localparam logic [2:0] ENC_RUN     = 3'd2;
    localparam logic [2:0] ENC_LOAD    = 3'd3;
    localparam logic [2:0] ENC_SEND    = 3'd4;
    localparam logic [2:0] ENC_WAIT_TX = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_CLEAR   = ENC_CLEAR,
        ST_RUN     = ENC_RUN,
        ST_LOAD    = ENC_LOAD,
        ST_SEND    = ENC_SEND,
        ST_WAIT_TX = ENC_WAIT_TX
    } state_t;

    // Host command bytes
    localparam logic [7:0] CMD_START = 8'h53;  // 'S': restart and run
    localparam logic [7:0] CMD_STEP  = 8'h54;  // 'T': single step (optional)

    // Status byte leading every result frame
    localparam logic [7:0] STAT_DONE    = 8'h01;
    localparam logic [7:0] STAT_TIMEOUT = 8'h02;
    localparam logic [7:0] STAT_STEP    = 8'h03;

    // status, PC hi/lo, ACC hi/lo, CYC hi/lo
    localparam int FRAME_LEN = 7;

endpackage

// File: rtl/bip_debug_unit_if.sv
// Bus between the debug unit, the UART byte interfaces and the BIP core.
// slave = debug unit side, master = UART/BIP/host side.
interface bip_debug_unit_if #(
    parameter int PC_W  = 11,
    parameter int ACC_W = 16
);
    logic [7:0]       rx_data;
    logic             rx_done;
    logic             tx_done;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             bip_enable;
    logic             bip_reset;
    logic             finish_program;
    logic [PC_W-1:0]  bip_pc;
    logic [ACC_W-1:0] bip_acc;
    logic             busy;

    modport slave (
        input  rx_data, rx_done, tx_done, finish_program, bip_pc, bip_acc,
        output tx_start, tx_data, bip_enable, bip_reset, busy
    );

    modport master (
        output rx_data, rx_done, tx_done, finish_program, bip_pc, bip_acc,
        input  tx_start, tx_data, bip_enable, bip_reset, busy
    );
endinterface

// File: rtl/bip_cycle_counter.sv
// Executed-cycle counter: synchronous clear, count enable, saturates at
// all-ones (o_sat) instead of wrapping.
module bip_cycle_counter #(
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CYC_W-1:0] o_count,
    output logic             o_sat
);
    logic [CYC_W-1:0] r_count_reg;

    assign o_sat   = &r_count_reg;
    assign o_count = r_count_reg;

    // Count enabled cycles, hold at all-ones once reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count_reg <= '0;
        end else if (i_clear) begin
            r_count_reg <= '0;
        end else if (i_enable && !o_sat) begin
            r_count_reg <= r_count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/bip_debug_unit.sv
// BIP debug/host stage: 'S' restarts and runs the BIP, counts enabled cycles
// until HLT or counter saturation, then sends a 7-byte result frame over UART.
// Optional macro BIP_DEBUG_STEP_EN adds the 'T' single-step command.
module bip_debug_unit #(
    parameter int         PC_W      = 11,
    parameter int         ACC_W     = 16,
    parameter int         CYC_W     = 16,
    parameter logic [7:0] CMD_START = bip_debug_pkg::CMD_START
) (
    input  logic           clk,
    input  logic           reset,
    bip_debug_unit_if.slave dbg
);
    import bip_debug_pkg::*;

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    state_t           r_state_reg, w_state_next;
    logic [7:0]       r_status_reg, w_status_next;
    logic             r_step_reg, w_step_next;
    logic [2:0]       r_idx_reg;
    logic [2:0]       w_idx_inc;
    logic [7:0]       r_tx_data_reg;
    logic [7:0]       r_frame_reg [FRAME_LEN];
    logic [7:0]       w_frame_byte [FRAME_LEN];
    logic [8*FRAME_LEN-1:0] w_frame_flat;
    logic             w_enable;
    logic             w_cnt_clear;
    logic [CYC_W-1:0] w_count;
    logic             w_sat;
    logic [15:0]      w_pc16, w_acc16, w_cyc16;

    bip_cycle_counter #(.CYC_W(CYC_W)) u_cycle_counter (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_cnt_clear),
        .i_enable (w_enable),
        .o_count  (w_count),
        .o_sat    (w_sat)
    );

    // Fields are zero-extended / truncated to 16 bits, sent MSB first
    assign w_pc16       = 16'(dbg.bip_pc[PC_W-1:0]);
    assign w_acc16      = 16'(dbg.bip_acc[ACC_W-1:0]);
    assign w_cyc16      = 16'(w_count);
    assign w_frame_flat = {r_status_reg, w_pc16, w_acc16, w_cyc16};
    assign w_idx_inc    = r_idx_reg + 3'd1;

    genvar gi;
    generate
        for (gi = 0; gi < FRAME_LEN; gi++) begin : g_frame
            assign w_frame_byte[gi] = w_frame_flat[8*(FRAME_LEN-1-gi) +: 8];

            // Snapshot each frame byte while in LOAD (BIP is disabled there)
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_frame_reg[gi] <= '0;
                end else if (r_state_reg == ST_LOAD) begin
                    r_frame_reg[gi] <= w_frame_byte[gi];
                end
            end
        end
    endgenerate

    // State, status and step-mode registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_reg  <= ST_IDLE;
            r_status_reg <= '0;
            r_step_reg   <= 1'b0;
        end else begin
            r_state_reg  <= w_state_next;
            r_status_reg <= w_status_next;
            r_step_reg   <= w_step_next;
        end
    end

    // Byte index and tx_data; tx_data is loaded on the edge into SEND and
    // then held until the next byte (and through IDLE)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx_reg     <= '0;
            r_tx_data_reg <= '0;
        end else if (r_state_reg == ST_LOAD) begin
            r_idx_reg     <= '0;
            r_tx_data_reg <= w_frame_byte[0];
        end else if (r_state_reg == ST_WAIT_TX && dbg.tx_done && r_idx_reg != LAST_IDX) begin
            r_idx_reg     <= w_idx_inc;
            r_tx_data_reg <= r_frame_reg[w_idx_inc];
        end
    end

    // Next-state logic; BIP enable drops in the same cycle RUN is left so
    // the core gets no enabled edge after finishing or timing out
    always_comb begin
        w_state_next  = r_state_reg;
        w_status_next = r_status_reg;
        w_step_next   = r_step_reg;
        w_enable      = 1'b0;
        w_cnt_clear   = 1'b0;
        case (r_state_reg)
            ST_IDLE: begin
                if (dbg.rx_done) begin
                    if (dbg.rx_data == CMD_START) begin
                        w_state_next = ST_CLEAR;
                        w_cnt_clear  = 1'b1;
                        w_step_next  = 1'b0;
                    end
`ifdef BIP_DEBUG_STEP_EN
                    else if (dbg.rx_data == CMD_STEP) begin
                        w_state_next = ST_RUN;
                        w_step_next  = 1'b1;
                    end
`endif
                end
            end
            ST_CLEAR: w_state_next = ST_RUN;
            ST_RUN: begin
                if (dbg.finish_program) begin
                    w_status_next = STAT_DONE;
                    w_state_next  = ST_LOAD;
                end else if (w_sat) begin
                    w_status_next = STAT_TIMEOUT;
                    w_state_next  = ST_LOAD;
                end else begin
                    w_enable = 1'b1;
                    if (r_step_reg) begin
                        w_status_next = STAT_STEP;
                        w_state_next  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: w_state_next = ST_SEND;
            ST_SEND: w_state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (dbg.tx_done) begin
                    w_state_next = (r_idx_reg == LAST_IDX) ? ST_IDLE : ST_SEND;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign dbg.tx_start   = (r_state_reg == ST_SEND);
    assign dbg.tx_data    = r_tx_data_reg;
    assign dbg.bip_enable = w_enable;
    assign dbg.bip_reset  = (r_state_reg == ST_CLEAR);
    assign dbg.busy       = (r_state_reg != ST_IDLE);

endmodule

// File: tb/tb_bip_debug_unit.sv
// Testbench for bip_debug_unit: a 16-bit-counter instance and a 4-bit-counter
// instance share host stimulus (selected by sel4) and a behavioural BIP model.
module tb_bip_debug_unit;
    import bip_debug_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_done;
    logic        sel4;
    int          halt_at;
    logic [10:0] pc_off;
    logic [15:0] acc_val;
    int          exec_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt = 0, brst_cnt = 0, txs_cnt = 0;

    always #5 clk = ~clk;

    bip_debug_unit_if #(.PC_W(11), .ACC_W(16)) bus16 ();
    bip_debug_unit_if #(.PC_W(11), .ACC_W(16)) bus4 ();

    logic        w_finish;
    logic [10:0] w_pc;
    logic        w_tx_start, w_en, w_brst, w_busy;
    logic [7:0]  w_tx_data;

    // BIP model: finishes after halt_at enabled cycles, PC = offset + executed
    assign w_finish = (exec_cnt >= halt_at);
    assign w_pc     = pc_off + 11'(exec_cnt);

    assign bus16.rx_data        = rx_data;
    assign bus16.rx_done        = rx_done & ~sel4;
    assign bus16.tx_done        = tx_done & ~sel4;
    assign bus16.finish_program = w_finish;
    assign bus16.bip_pc         = w_pc;
    assign bus16.bip_acc        = acc_val;
    assign bus4.rx_data         = rx_data;
    assign bus4.rx_done         = rx_done & sel4;
    assign bus4.tx_done         = tx_done & sel4;
    assign bus4.finish_program  = w_finish;
    assign bus4.bip_pc          = w_pc;
    assign bus4.bip_acc         = acc_val;

    assign w_tx_start = sel4 ? bus4.tx_start   : bus16.tx_start;
    assign w_tx_data  = sel4 ? bus4.tx_data    : bus16.tx_data;
    assign w_en       = sel4 ? bus4.bip_enable : bus16.bip_enable;
    assign w_brst     = sel4 ? bus4.bip_reset  : bus16.bip_reset;
    assign w_busy     = sel4 ? bus4.busy       : bus16.busy;

    bip_debug_unit #(.PC_W(11), .ACC_W(16), .CYC_W(16), .CMD_START(8'h53)) dut16 (
        .clk(clk), .reset(reset), .dbg(bus16.slave));
    bip_debug_unit #(.PC_W(11), .ACC_W(16), .CYC_W(4), .CMD_START(8'h53)) dut4 (
        .clk(clk), .reset(reset), .dbg(bus4.slave));

    // BIP core model
    always @(posedge clk) begin
        if (w_brst)    exec_cnt <= 0;
        else if (w_en) exec_cnt <= exec_cnt + 1;
    end

    // Event monitor
    always @(negedge clk) begin
        if (w_en)       en_cnt++;
        if (w_brst)     brst_cnt++;
        if (w_tx_start) txs_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] frame_of(input logic [7:0] st, input int pc,
                                             input logic [15:0] acc, input int cyc);
        return {st, 16'(pc & 'h7FF), acc, 16'(cyc)};
    endfunction

    // Send one command byte; either expect a full frame or expect it ignored
    task automatic run_cmd(input string name, input logic [7:0] cmd, input bit exp_frame,
                           input logic [55:0] exp, input int delay, input int budget,
                           input int exp_en, input int exp_rst);
        int en0, r0, t0, waited;
        logic [7:0] b;
        logic [55:0] got;
        bit hold_ok;
        en0 = en_cnt; r0 = brst_cnt; t0 = txs_cnt; got = '0;
        @(negedge clk); rx_data = cmd; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
        if (!exp_frame) begin
            repeat (5) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk); tx_done = 1'b0;
            repeat (10) @(negedge clk);
            chk({name, "_busy"}, 64'(w_busy), 64'd0);
            chk({name, "_txstarts"}, 64'(txs_cnt - t0), 64'd0);
        end else begin
            waited = 0;
            while (!w_tx_start && waited < budget) begin
                @(negedge clk); waited++;
            end
            if (!w_tx_start) begin
                chk({name, "_first_tx_start_timeout"}, 64'd0, 64'd1);
                return;
            end
            for (int k = 0; k < FRAME_LEN; k++) begin
                b = w_tx_data;
                got[8*(FRAME_LEN-1-k) +: 8] = b;
                chk($sformatf("%s_byte%0d", name, k), 64'(b), 64'(exp[8*(FRAME_LEN-1-k) +: 8]));
                hold_ok = 1'b1;
                repeat (delay + 1) begin
                    @(negedge clk);
                    if (w_tx_start || w_tx_data !== b) hold_ok = 1'b0;
                end
                chk($sformatf("%s_hold%0d", name, k), 64'(hold_ok), 64'd1);
                tx_done = 1'b1;
                @(negedge clk); tx_done = 1'b0;
                chk($sformatf("%s_start_after_done%0d", name, k), 64'(w_tx_start),
                    64'(k < FRAME_LEN - 1));
            end
            repeat (3) @(negedge clk);
            chk({name, "_busy_end"}, 64'(w_busy), 64'd0);
            chk({name, "_idle_txdata"}, 64'(w_tx_data), 64'(exp[7:0]));
            chk({name, "_txstarts"}, 64'(txs_cnt - t0), 64'(FRAME_LEN));
        end
        chk({name, "_enables"}, 64'(en_cnt - en0), 64'(exp_en));
        chk({name, "_bip_resets"}, 64'(brst_cnt - r0), 64'(exp_rst));
        $display("tb: %s cmd=%02h frame=%014h expected=%014h", name, cmd, got, exp_frame ? exp : 56'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0; sel4 = 1'b0;
        halt_at = 1 << 30; pc_off = '0; acc_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 64'(w_tx_start), 64'd0);
        chk("rst_tx_data",  64'(w_tx_data),  64'd0);
        chk("rst_enable",   64'(w_en),       64'd0);
        chk("rst_bip_reset",64'(w_brst),     64'd0);
        chk("rst_busy",     64'(w_busy),     64'd0);
        chk("rst_busy4",    64'(bus4.busy),  64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed: finish after 10 cycles, slow UART
        halt_at = 10; pc_off = 11'h7FB; acc_val = 16'h00FF;
        run_cmd("directed", 8'h53, 1'b1, 56'h01_0005_00FF_000A, 100, 200, 10, 1);

        // Randomized runs
        for (int i = 0; i < 5; i++) begin
            n = int'($urandom_range(0, 40));
            halt_at = n; pc_off = 11'($urandom); acc_val = 16'($urandom);
            run_cmd($sformatf("rand%0d", i), 8'h53, 1'b1, frame_of(STAT_DONE, int'(pc_off) + n, acc_val, n),
                    int'($urandom_range(0, 4)), 200, n, 1);
        end

        // Non-start bytes in IDLE
        run_cmd("ignore_A", 8'h41, 1'b0, '0, 0, 0, 0, 0);
`ifndef BIP_DEBUG_STEP_EN
        run_cmd("ignore_T", 8'h54, 1'b0, '0, 0, 0, 0, 0);
`endif

        // Reset in the middle of RUN, then a clean restart
        halt_at = 1 << 30;
        @(negedge clk); rx_data = 8'h53; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrun_busy", 64'(w_busy), 64'd1);
        chk("midrun_enable", 64'(w_en), 64'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_enable", 64'(w_en), 64'd0);
        @(negedge clk);
        chk("rst_run_enable",   64'(w_en),       64'd0);
        chk("rst_run_tx_start", 64'(w_tx_start), 64'd0);
        chk("rst_run_busy",     64'(w_busy),     64'd0);
        reset = 1'b0;
        @(negedge clk);
        n = int'($urandom_range(1, 30));
        halt_at = n; pc_off = 11'($urandom); acc_val = 16'($urandom);
        run_cmd("restart", 8'h53, 1'b1, frame_of(STAT_DONE, int'(pc_off) + n, acc_val, n), 1, 200, n, 1);

        // Timeout on the 4-bit counter instance
        sel4 = 1'b1;
        halt_at = 1 << 30; pc_off = 11'($urandom); acc_val = 16'($urandom);
        run_cmd("timeout4", 8'h53, 1'b1, frame_of(STAT_TIMEOUT, int'(pc_off) + 15, acc_val, 15), 2, 100, 15, 1);
        sel4 = 1'b0;

`ifdef BIP_DEBUG_STEP_EN
        // Immediate finish, then three single steps, then a step while halted
        halt_at = 0; pc_off = 11'($urandom); acc_val = 16'($urandom);
        run_cmd("step_start", 8'h53, 1'b1, frame_of(STAT_DONE, int'(pc_off), acc_val, 0), 1, 100, 0, 1);
        halt_at = 1000;
        for (int k = 1; k <= 3; k++) begin
            run_cmd($sformatf("step%0d", k), 8'h54, 1'b1,
                    frame_of(STAT_STEP, int'(pc_off) + k, acc_val, k), 1, 100, 1, 0);
        end
        halt_at = 3;
        run_cmd("step_halted", 8'h54, 1'b1, frame_of(STAT_DONE, int'(pc_off) + 3, acc_val, 3), 1, 100, 0, 0);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bip_debug_unit.md
Name: bip_debug_unit

Overview:
- Debug/host-interface stage sitting between the UART (rx/tx byte interfaces) and the BIP core.
- Takes host commands, gates the BIP enable, and counts executed clock cycles.
- Consumes the core's finish_program, PC and accumulator, and reports a fixed 7-byte result frame over UART TX.

Parameters:
- PC_W, 11, width of BIP program counter
- ACC_W, 16, width of BIP accumulator
- CYC_W, 16, width of cycle counter; saturation at 2^CYC_W-1 means timeout
- CMD_START, 8'h53, command byte ('S') that restarts and runs the program

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte, valid when rx_done=1
- rx_done  in  1  one-cycle pulse, new byte received
- tx_done  in  1  one-cycle pulse, UART finished the current byte
- tx_start  out  1  one-cycle pulse, launch tx_data
- tx_data  out  8  byte to transmit; held stable until tx_done
- bip_enable  out  1  BIP execution enable
- bip_reset  out  1  one-cycle synchronous restart pulse to the BIP (PC to 0)
- finish_program  in  1  level from BIP, program reached HLT
- bip_pc  in  PC_W  BIP program counter
- bip_acc  in  ACC_W  BIP accumulator
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async):
  - state=IDLE; bip_enable=0; bip_reset=0; tx_start=0; tx_data=0; busy=0.
  - Cycle counter and latched registers cleared to 0.
- FSM states: IDLE, CLEAR, RUN, LOAD, SEND, WAIT_TX.
- IDLE:
  - rx_done with rx_data==CMD_START -> CLEAR. bip_reset=1 for exactly the next cycle; cycle counter cleared.
  - Any other byte is ignored.
  - finish_program is ignored in IDLE.
- CLEAR: one cycle, then RUN. bip_enable rises in the first RUN cycle.
- RUN:
  - bip_enable=1; counter increments by 1 every RUN cycle, starting at 1.
  - finish_program=1 -> LOAD with status 8'h01.
  - Counter reaching all-ones -> LOAD with status 8'h02 (timeout); counter saturates, no wrap.
  - Both events in the same cycle -> status 8'h01.
  - rx bytes are ignored.
- LOAD:
  - bip_enable=0 combinationally on leaving RUN, so the BIP sees no enabled edge after the finish cycle.
  - Latch bip_pc (zero-extended to 16), bip_acc (zero-extended to 16 if ACC_W<16) and the counter into a 7-byte frame.
  - Byte index=0; go to SEND.
- Frame order: status, PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], CYC[15:8], CYC[7:0]. Fields are MSB first; CYC_W>16 is truncated to the low 16 bits.
- SEND: tx_data=frame[idx]; tx_start=1 for one cycle -> WAIT_TX.
- WAIT_TX:
  - On tx_done: if idx==6 -> IDLE; else idx+1 -> SEND. Inter-byte latency is 1 cycle after tx_done.
  - tx_done outside WAIT_TX is ignored.
- tx_data holds its last value in IDLE.
- Reset mid-frame: transmission aborts immediately; no partial resume.

Optional Feature:
- Macro: BIP_DEBUG_STEP_EN
- Defined:
  - Command byte 8'h54 ('T') in IDLE gives a single-step: bip_enable=1 for exactly one cycle (no bip_reset, counter += 1, not cleared).
  - Then LOAD with status 8'h03, and the frame is sent as normal.
  - 'T' while finish_program=1 sends the frame with status 8'h01 and no enable pulse.
- Undefined: 8'h54 is ignored like any other non-start byte; the status set is {01,02}.

Decomposition:
- Package bip_debug_pkg holds:
  - state encoding localparams;
  - CMD_START/CMD_STEP byte constants;
  - status codes STAT_DONE=01, STAT_TIMEOUT=02, STAT_STEP=03;
  - FRAME_LEN=7.
- One natural sub-module: bip_cycle_counter (clear/enable/saturate, CYC_W wide, sat flag output). Everything else stays inline.

Test Plan:
- Reset asserted mid-RUN -> next edge: bip_enable=0, tx_start=0, busy=0; a following 'S' restarts cleanly.
- Send 8'h53, BIP model raises finish_program after 10 RUN cycles with pc=11'h005, acc=16'h00FF -> frame 01 00 05 00 FF 00 0A.
- CYC_W=4, finish_program never asserted -> after 15 RUN cycles frame status 02, CYC bytes 00 0F; bip_enable low from that cycle.
- Send 8'h41 and 8'h54 (step macro undefined) in IDLE -> no bip_reset, no bip_enable, no tx_start.
- tx_done delayed 100 cycles per byte -> exactly 7 tx_start pulses, each one cycle after the preceding tx_done; tx_data stable between them; spurious tx_done in IDLE has no effect.
- BIP_DEBUG_STEP_EN defined: 'S' then an immediate finish, then 'T' three times -> each step frame has status 03 and the CYC field increments by 1.
